// File: rtl/router_fsm_n_pkg.sv
// Shared state encodings and helpers for the parametrised router control FSM.
package router_fsm_n_pkg;

    localparam int ROUTER_MAX_PORTS = 4;

    localparam logic [3:0] DECODE_ADDRESS     = 4'd0;
    localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
    localparam logic [3:0] LOAD_DATA          = 4'd2;
    localparam logic [3:0] LOAD_PARITY        = 4'd3;
    localparam logic [3:0] CHECK_PARITY_ERROR = 4'd4;
    localparam logic [3:0] FIFO_FULL_STATE    = 4'd5;
    localparam logic [3:0] LOAD_AFTER_FULL    = 4'd6;
    localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd7;
    localparam logic [3:0] DROP_PACKET        = 4'd8;

    // Bits needed to hold values 0..n-1 (minimum 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/router_fsm_n_if.sv
// Handshake/status bundle between the register block, output FIFOs and the router FSM.
interface router_fsm_n_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
);
    logic                 pkt_valid;
    logic [ADDR_W-1:0]    data_in;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 parity_done;
    logic                 low_packet_valid;

    logic [NUM_PORTS-1:0] dest_sel;
    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 rst_int_reg;
    logic                 write_enb_reg;
    logic                 busy;
    logic                 drop_state;
    logic                 wait_timeout;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_packet_valid,
        input  dest_sel, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, busy, drop_state, wait_timeout
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_packet_valid,
        output dest_sel, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, busy, drop_state, wait_timeout
    );
endinterface

// File: rtl/router_fsm_n_wait_timer.sv
// Cycle counter bounding how long the FSM may sit in WAIT_TILL_EMPTY.
module router_wait_timer
    import router_fsm_n_pkg::*;
#(
    parameter int LIMIT = 30
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    // expired asserts during the LIMIT-th enabled cycle, so the exit edge lands exactly on LIMIT.
    assign expired = (cnt == W'(LIMIT - 1));

    always_ff @(posedge clock) begin
        if (!resetn)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/router_fsm_n.sv
// Router control FSM for NUM_PORTS output FIFOs with bad-address drop.
// Optional wait-till-empty timeout enabled by defining ROUTER_WAIT_TIMEOUT_EN.
module router_fsm_n
    import router_fsm_n_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 30
) (
    input  logic            clock,
    input  logic            resetn,
    router_fsm_n_if.slave   bus
);
    if (NUM_PORTS < 2 || NUM_PORTS > ROUTER_MAX_PORTS) begin : g_bad_ports
        $error("router_fsm_n: NUM_PORTS out of range");
    end
    if ((1 << ADDR_W) < NUM_PORTS) begin : g_bad_addr
        $error("router_fsm_n: ADDR_W too narrow for NUM_PORTS");
    end
    if (WAIT_TIMEOUT < 1) begin : g_bad_timeout
        $error("router_fsm_n: WAIT_TIMEOUT must be >= 1");
    end

    logic [3:0]           state, next_state;
    logic [NUM_PORTS-1:0] dest_sel;
    logic [NUM_PORTS-1:0] hdr_onehot;
    logic                 addr_ok, hdr_accept, hdr_empty, dest_empty, soft_hit, timer_exp;

    assign addr_ok    = (int'(bus.data_in) < NUM_PORTS);
    assign hdr_onehot = NUM_PORTS'(1) << bus.data_in;
    assign hdr_accept = (state == DECODE_ADDRESS) && bus.pkt_valid && addr_ok;
    assign hdr_empty  = |(bus.fifo_empty & hdr_onehot);
    assign dest_empty = |(bus.fifo_empty & dest_sel);
    assign soft_hit   = |(bus.soft_reset & dest_sel);

`ifdef ROUTER_WAIT_TIMEOUT_EN
    logic wait_timeout_q;

    router_wait_timer #(.LIMIT(WAIT_TIMEOUT)) u_wait_timer (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (state != WAIT_TILL_EMPTY),
        .enable  (state == WAIT_TILL_EMPTY),
        .expired (timer_exp)
    );

    always_ff @(posedge clock) begin
        if (!resetn)
            wait_timeout_q <= 1'b0;
        else
            wait_timeout_q <= (state == WAIT_TILL_EMPTY) && (next_state == DROP_PACKET);
    end
    assign bus.wait_timeout = wait_timeout_q;
`else
    assign timer_exp        = 1'b0;
    assign bus.wait_timeout = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && addr_ok) next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                else if (bus.pkt_valid)       next_state = DROP_PACKET;
            end
            LOAD_FIRST_DATA:    next_state = LOAD_DATA;
            WAIT_TILL_EMPTY: begin
                if (dest_empty)     next_state = LOAD_FIRST_DATA;
                else if (timer_exp) next_state = DROP_PACKET;
            end
            LOAD_DATA: begin
                if (bus.fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) next_state = LOAD_PARITY;
            end
            LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
            FIFO_FULL_STATE:    if (!bus.fifo_full) next_state = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)           next_state = DECODE_ADDRESS;
                else if (bus.low_packet_valid) next_state = LOAD_PARITY;
                else                           next_state = LOAD_DATA;
            end
            CHECK_PARITY_ERROR: next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET:        if (!bus.pkt_valid) next_state = DECODE_ADDRESS;
            default:            next_state = DECODE_ADDRESS;
        endcase
        // Soft reset of the selected port aborts a packet in flight, but not a decode or drop.
        if (soft_hit && state != DECODE_ADDRESS && state != DROP_PACKET)
            next_state = DECODE_ADDRESS;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            dest_sel <= '0;
        end else begin
            state <= next_state;
            if (hdr_accept) dest_sel <= hdr_onehot;
        end
    end

    assign bus.dest_sel      = dest_sel;
    assign bus.detect_add    = (state == DECODE_ADDRESS);
    assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state == LOAD_DATA);
    assign bus.laf_state     = (state == LOAD_AFTER_FULL);
    assign bus.full_state    = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign bus.drop_state    = (state == DROP_PACKET);
    assign bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);
    assign bus.busy          = (state == LOAD_FIRST_DATA) || (state == LOAD_PARITY) ||
                               (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL) ||
                               (state == WAIT_TILL_EMPTY) || (state == CHECK_PARITY_ERROR);
endmodule

// File: tb/tb_router_fsm_n.sv
// Vector-table bench for router_fsm_n (NUM_PORTS=3, WAIT_TIMEOUT=4); timeout cases follow ROUTER_WAIT_TIMEOUT_EN.
module tb_router_fsm_n;
    logic clock;
    logic resetn;

    router_fsm_n_if #(.NUM_PORTS(3), .ADDR_W(2)) bif ();

    router_fsm_n #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum int {S_DEC, S_LFD, S_LD, S_LP, S_CPE, S_FFS, S_LAF, S_WTE, S_DROP} st_e;

    typedef struct packed {
        logic [2:0] dest;
        logic da, lfd, ld, laf, full, rst, web, busy, drop, wto;
    } out_t;

    typedef struct {
        logic       rn, pv;
        logic [1:0] addr;
        logic       ff;
        logic [2:0] fe, sr;
        logic       pd, lpv;
        st_e        st;
        logic [2:0] dest;
        logic       wto;
    } vec_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Output pattern expected for a given architectural state.
    function automatic out_t mk(input st_e s, input logic [2:0] d, input logic w);
        out_t o;
        o = '0;
        o.dest = d;
        o.wto  = w;
        case (s)
            S_DEC:  o.da = 1'b1;
            S_LFD:  begin o.lfd = 1'b1; o.busy = 1'b1; end
            S_LD:   begin o.ld = 1'b1; o.web = 1'b1; end
            S_LP:   begin o.web = 1'b1; o.busy = 1'b1; end
            S_CPE:  begin o.rst = 1'b1; o.busy = 1'b1; end
            S_FFS:  begin o.full = 1'b1; o.busy = 1'b1; end
            S_LAF:  begin o.laf = 1'b1; o.web = 1'b1; o.busy = 1'b1; end
            S_WTE:  o.busy = 1'b1;
            S_DROP: o.drop = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic add(input logic rn, pv, input logic [1:0] a, input logic ff,
                       input logic [2:0] fe, sr, input logic pd, lpv,
                       input st_e s, input logic [2:0] d, input logic w);
        vec_t v;
        v.rn = rn; v.pv = pv; v.addr = a; v.ff = ff; v.fe = fe; v.sr = sr;
        v.pd = pd; v.lpv = lpv; v.st = s; v.dest = d; v.wto = w;
        tbl.push_back(v);
    endtask

    task automatic apply(input int idx, input vec_t v);
        out_t g, e;
        @(negedge clock);
        resetn               = v.rn;
        bif.pkt_valid        = v.pv;
        bif.data_in          = v.addr;
        bif.fifo_full        = v.ff;
        bif.fifo_empty       = v.fe;
        bif.soft_reset       = v.sr;
        bif.parity_done      = v.pd;
        bif.low_packet_valid = v.lpv;
        exp_q.push_back(mk(v.st, v.dest, v.wto));
        @(posedge clock);
        #1;
        g = {bif.dest_sel, bif.detect_add, bif.lfd_state, bif.ld_state, bif.laf_state,
             bif.full_state, bif.rst_int_reg, bif.write_enb_reg, bif.busy, bif.drop_state,
             bif.wait_timeout};
        e = exp_q.pop_front();
        checks++;
        if (g !== e)
            $display("FAIL step%0d (%s): got %b required %b", idx, v.st.name(), g, e);
        else
            passed++;
    endtask

    initial begin
        resetn = 1'b0;
        bif.pkt_valid = 0; bif.data_in = '0; bif.fifo_full = 0; bif.fifo_empty = '1;
        bif.soft_reset = '0; bif.parity_done = 0; bif.low_packet_valid = 0;

        //   rn pv ad ff fe sr pd lp  state   dest wto
        add(0, 0, 0, 0, 7, 0, 0, 0, S_DEC,  0, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_DEC,  0, 0);
        // addr 1 to empty FIFO, then packet end
        add(1, 1, 1, 0, 7, 0, 0, 0, S_LFD,  2, 0);
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LD,   2, 0);
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LD,   2, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_LP,   2, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_CPE,  2, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_DEC,  2, 0);
        // addr 2 with FIFO 2 not empty: short wait (below timeout)
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 7, 0, 0, 0, S_LFD,  4, 0);
        add(1, 1, 2, 0, 7, 0, 0, 0, S_LD,   4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_LP,   4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_CPE,  4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_DEC,  4, 0);
        // bad address: drop, dest kept, soft reset ignored in DROP and DECODE
        add(1, 1, 3, 0, 7, 0, 0, 0, S_DROP, 4, 0);
        add(1, 1, 3, 0, 7, 4, 0, 0, S_DROP, 4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_DEC,  4, 0);
        add(1, 0, 0, 0, 7, 4, 0, 0, S_DEC,  4, 0);
        // full handling: FFS, LAF, low_packet_valid -> LP, CPE full -> FFS, parity_done -> DEC
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LFD,  1, 0);
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LD,   1, 0);
        add(1, 1, 0, 1, 7, 0, 0, 0, S_FFS,  1, 0);
        add(1, 1, 0, 1, 7, 0, 0, 0, S_FFS,  1, 0);
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LAF,  1, 0);
        add(1, 0, 0, 0, 7, 0, 0, 1, S_LP,   1, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_CPE,  1, 0);
        add(1, 0, 0, 1, 7, 0, 0, 0, S_FFS,  1, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_LAF,  1, 0);
        add(1, 0, 0, 0, 7, 0, 1, 0, S_DEC,  1, 0);
        // LAF with neither flag returns to LD
        add(1, 1, 2, 0, 7, 0, 0, 0, S_LFD,  4, 0);
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LD,   4, 0);
        add(1, 1, 0, 1, 7, 0, 0, 0, S_FFS,  4, 0);
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LAF,  4, 0);
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LD,   4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_LP,   4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_CPE,  4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_DEC,  4, 0);
        // soft reset: other port ignored, own port aborts; also aborts WTE
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LFD,  1, 0);
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LD,   1, 0);
        add(1, 1, 0, 0, 7, 4, 0, 0, S_LD,   1, 0);
        add(1, 1, 0, 0, 7, 1, 0, 0, S_DEC,  1, 0);
        add(1, 0, 0, 0, 7, 1, 0, 0, S_DEC,  1, 0);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 3, 4, 0, 0, S_DEC,  4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_DEC,  4, 0);
        // synchronous reset mid-packet
        add(1, 1, 1, 0, 7, 0, 0, 0, S_LFD,  2, 0);
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LD,   2, 0);
        add(0, 1, 0, 0, 7, 0, 0, 0, S_DEC,  0, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_DEC,  0, 0);
`ifdef ROUTER_WAIT_TIMEOUT_EN
        // timeout after 4 WTE cycles, one-cycle wait_timeout pulse
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_DROP, 4, 1);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_DROP, 4, 0);
        add(1, 0, 0, 0, 3, 0, 0, 0, S_DEC,  4, 0);
        // empty and expiry in the same cycle: empty wins
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        add(1, 1, 2, 0, 7, 0, 0, 0, S_LFD,  4, 0);
`else
        // without the timer WTE waits past WAIT_TIMEOUT
        add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE,  4, 0);
        for (int k = 0; k < 6; k++)
            add(1, 1, 2, 0, 3, 0, 0, 0, S_WTE, 4, 0);
        add(1, 1, 2, 0, 7, 0, 0, 0, S_LFD,  4, 0);
`endif
        add(1, 1, 0, 0, 7, 0, 0, 0, S_LD,   4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_LP,   4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_CPE,  4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0, S_DEC,  4, 0);

        for (int i = 0; i < tbl.size(); i++)
            apply(i, tbl[i]);

        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: left %0d required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
